stage5_control_fsm: RTL and testbench
=====================================

Name: stage5_control_fsm

Overview:
- Multicycle control sequencer for the stage-5 integrated datapath: program counter, main stack pointer (MSP), return stack pointer (RSP), dual-port memory, and the ValA/ValB/IR registers.
- Generates every datapath control strobe from a registered state and the decoded IR opcode.
- Sits between the IR output (IROut[15:12]) and the datapath control inputs, replacing hand-driven testbench control.

Parameters:
- INIT_CYCLES, 5, cycles spent in INIT after reset with all controls deasserted (datapath settle time).
- CNT_W, 3, width of the init counter; must hold INIT_CYCLES-1.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  4  IROut[15:12]; sampled only in DECODE.
- MSPWrite, MSPPop, RSPWrite, RSPPop  out  1 each  stack pointer update strobes. Write+Pop=pop; Write alone=push.
- PCWrite, PCSource, PCAdd  out  1 each  PC load. PCSource 0=adder, 1=ValA. PCAdd 1=+1, 0=+SignExtOut.
- ValAWrite, ValBWrite, IRWrite  out  1 each  register load enables.
- MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes.
- MemDst1, MemDst2  out  2 each  address select: 00=PC, 01=MSP, 10=RSP, 11=ValA.
- MemData  out  3  write data select: 000=ValA, 001=ValB, 010=SignExtOut, 011=ZeroExtOut, 100=ResOut, 101=PC.
- State  out  4  current state encoding, for debug.
- Halted  out  1  high while in HALT.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Moore machine: all outputs decode from the registered state and the latched opcode. Every control not listed for a state is 0.
- Reset, sampled at a CLK rising edge, forces state INIT, counter 0, latched opcode 0. All outputs are 0 during reset and in INIT. Reset mid-instruction aborts the instruction with no further strobes.
- INIT: counter increments each cycle. Go to FETCH when counter == INIT_CYCLES-1.
- FETCH: PCAdd=1, PCSource=0, PCWrite=1, MemDst1=00, MemRead1=1, IRWrite=1. Next state DECODE.
- DECODE: latch Opcode. Branch by opcode; undefined opcode pulses Illegal and returns to FETCH (executes as NOP).
- Opcodes and execute states (cycle counts include FETCH and DECODE):
  - 0x0 PUSHI, 3 cycles. EX1: MemWrite1, MemDst1=01, MemData=010, MSPWrite.
  - 0x1 POP, 3 cycles. EX1: MSPWrite, MSPPop.
  - 0x2 ALU, 5 cycles.
    - EX1: MemRead1, MemDst1=01, ValAWrite, MSPWrite, MSPPop.
    - EX2: same as EX1 but ValBWrite instead of ValAWrite.
    - EX3: MemWrite1, MemDst1=01, MemData=100, MSPWrite.
  - 0x3 JUMP, 3 cycles. EX1: PCWrite, PCSource=0, PCAdd=0.
  - 0x4 CALL, 4 cycles.
    - EX1: MemWrite2, MemDst2=10, MemData=101, RSPWrite.
    - EX2: PCWrite, PCSource=0, PCAdd=0.
  - 0x5 RET, 4 cycles.
    - EX1: MemRead1, MemDst1=10, ValAWrite, RSPWrite, RSPPop.
    - EX2: PCWrite, PCSource=1.
  - 0xF HALT: go to HALT. Halted=1, all controls 0. Leave HALT only on Reset.
- The last execute state of every instruction returns to FETCH. There are no idle bubbles between instructions.
- Stack overflow and underflow are not detected; the pointers wrap in the datapath.
- The latched opcode is held stable from DECODE until the next DECODE, even if IROut changes.

Optional Feature:
- Macro: STAGE5_CTRL_STEP_EN.
- When defined: add input Step (1 bit). The FSM holds in FETCH with all controls 0 until Step is sampled high, then performs a normal FETCH on the following cycle. Step is ignored in every other state.
- When undefined: no Step port; FETCH is always a single cycle.

Test Plan:
- Reset, INIT_CYCLES=5 -> all outputs 0 for 5 cycles. 6th cycle: FETCH strobes PCWrite=1, PCAdd=1, MemRead1=1, IRWrite=1, MemDst1=00.
- Opcode 0x2 -> exact sequence FETCH, DECODE, EX1 (ValAWrite, pop), EX2 (ValBWrite, pop), EX3 (MemData=100, push), then FETCH; 5 cycles total.
- Opcode 0x4 then 0x5 -> CALL: MemWrite2=1, MemDst2=10, MemData=101, then PCAdd=0 PC write. RET: RSP pop with ValAWrite, then PCSource=1 PC write.
- Opcode 0x9 -> Illegal high for exactly the DECODE cycle, no other strobes, FETCH next.
- Opcode 0xF -> Halted=1 held for 20 cycles with all controls 0. Reset returns to INIT.
- Reset asserted during ALU EX2 -> next cycle state INIT, all strobes 0. With STAGE5_CTRL_STEP_EN: FETCH waits until a Step pulse.

Source files
------------

// File: rtl/stage5_control_fsm.sv
// Multicycle control sequencer for the stage-5 datapath (PC, MSP, RSP, dual-port memory, ValA/ValB/IR).
// Optional FETCH single-stepping is enabled by defining STAGE5_CTRL_STEP_EN, which adds the Step input.
module stage5_control_fsm #(
    parameter int unsigned INIT_CYCLES = 5,
    parameter int unsigned CNT_W       = 3
) (
    input  logic       CLK,
    input  logic       Reset,
`ifdef STAGE5_CTRL_STEP_EN
    input  logic       Step,
`endif
    input  logic [3:0] Opcode,
    output logic       MSPWrite,
    output logic       MSPPop,
    output logic       RSPWrite,
    output logic       RSPPop,
    output logic       PCWrite,
    output logic       PCSource,
    output logic       PCAdd,
    output logic       ValAWrite,
    output logic       ValBWrite,
    output logic       IRWrite,
    output logic       MemRead1,
    output logic       MemRead2,
    output logic       MemWrite1,
    output logic       MemWrite2,
    output logic [1:0] MemDst1,
    output logic [1:0] MemDst2,
    output logic [2:0] MemData,
    output logic [3:0] State,
    output logic       Halted,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_INIT   = 4'h0,
        S_FETCH  = 4'h1,
        S_DECODE = 4'h2,
        S_EX1    = 4'h3,
        S_EX2    = 4'h4,
        S_EX3    = 4'h5,
        S_HALT   = 4'hF
    } state_e;

    typedef enum logic [3:0] {
        OP_PUSHI = 4'h0,
        OP_POP   = 4'h1,
        OP_ALU   = 4'h2,
        OP_JUMP  = 4'h3,
        OP_CALL  = 4'h4,
        OP_RET   = 4'h5,
        OP_HALT  = 4'hF
    } opcode_e;

    localparam logic [1:0] DST_PC  = 2'b00;
    localparam logic [1:0] DST_MSP = 2'b01;
    localparam logic [1:0] DST_RSP = 2'b10;
    localparam logic [2:0] DAT_SEXT = 3'b010;
    localparam logic [2:0] DAT_RES  = 3'b100;
    localparam logic [2:0] DAT_PC   = 3'b101;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             fetch_active;

`ifdef STAGE5_CTRL_STEP_EN
    logic armed_q, armed_d;
    assign fetch_active = armed_q;
`else
    assign fetch_active = 1'b1;
`endif

    function automatic logic op_known(input logic [3:0] op);
        case (op)
            OP_PUSHI, OP_POP, OP_ALU, OP_JUMP, OP_CALL, OP_RET, OP_HALT: op_known = 1'b1;
            default:                                                    op_known = 1'b0;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            op_q    <= '0;
`ifdef STAGE5_CTRL_STEP_EN
            armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
`ifdef STAGE5_CTRL_STEP_EN
            armed_q <= armed_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
`ifdef STAGE5_CTRL_STEP_EN
        armed_d = armed_q;
`endif
        case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) state_d = S_FETCH;
                else                                  cnt_d   = cnt_q + CNT_W'(1);
            end
            S_FETCH: begin
`ifdef STAGE5_CTRL_STEP_EN
                // Step only arms the fetch; the real FETCH strobes come a cycle later.
                if (armed_q) begin
                    state_d = S_DECODE;
                    armed_d = 1'b0;
                end else if (Step) begin
                    armed_d = 1'b1;
                end
`else
                state_d = S_DECODE;
`endif
            end
            S_DECODE: begin
                op_d = Opcode;
                case (Opcode)
                    OP_PUSHI, OP_POP, OP_ALU, OP_JUMP, OP_CALL, OP_RET: state_d = S_EX1;
                    OP_HALT:                                            state_d = S_HALT;
                    default:                                            state_d = S_FETCH;
                endcase
            end
            S_EX1: begin
                case (op_q)
                    OP_ALU, OP_CALL, OP_RET: state_d = S_EX2;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_EX2:   state_d = (op_q == OP_ALU) ? S_EX3 : S_FETCH;
            S_EX3:   state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        MSPWrite  = 1'b0;
        MSPPop    = 1'b0;
        RSPWrite  = 1'b0;
        RSPPop    = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        PCAdd     = 1'b0;
        ValAWrite = 1'b0;
        ValBWrite = 1'b0;
        IRWrite   = 1'b0;
        MemRead1  = 1'b0;
        MemRead2  = 1'b0;
        MemWrite1 = 1'b0;
        MemWrite2 = 1'b0;
        MemDst1   = DST_PC;
        MemDst2   = DST_PC;
        MemData   = '0;
        Halted    = 1'b0;
        Illegal   = 1'b0;
        State     = state_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_active) begin
                    PCAdd    = 1'b1;
                    PCWrite  = 1'b1;
                    MemDst1  = DST_PC;
                    MemRead1 = 1'b1;
                    IRWrite  = 1'b1;
                end
            end
            // IR is loaded at the end of FETCH, so the live opcode is valid here.
            S_DECODE: Illegal = !op_known(Opcode);
            S_EX1: begin
                case (op_q)
                    OP_PUSHI: begin
                        MemWrite1 = 1'b1;
                        MemDst1   = DST_MSP;
                        MemData   = DAT_SEXT;
                        MSPWrite  = 1'b1;
                    end
                    OP_POP: begin
                        MSPWrite = 1'b1;
                        MSPPop   = 1'b1;
                    end
                    OP_ALU: begin
                        MemRead1  = 1'b1;
                        MemDst1   = DST_MSP;
                        ValAWrite = 1'b1;
                        MSPWrite  = 1'b1;
                        MSPPop    = 1'b1;
                    end
                    OP_JUMP: PCWrite = 1'b1;
                    OP_CALL: begin
                        MemWrite2 = 1'b1;
                        MemDst2   = DST_RSP;
                        MemData   = DAT_PC;
                        RSPWrite  = 1'b1;
                    end
                    OP_RET: begin
                        MemRead1  = 1'b1;
                        MemDst1   = DST_RSP;
                        ValAWrite = 1'b1;
                        RSPWrite  = 1'b1;
                        RSPPop    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                case (op_q)
                    OP_ALU: begin
                        MemRead1  = 1'b1;
                        MemDst1   = DST_MSP;
                        ValBWrite = 1'b1;
                        MSPWrite  = 1'b1;
                        MSPPop    = 1'b1;
                    end
                    OP_CALL: PCWrite = 1'b1;
                    OP_RET: begin
                        PCWrite  = 1'b1;
                        PCSource = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX3: begin
                if (op_q == OP_ALU) begin
                    MemWrite1 = 1'b1;
                    MemDst1   = DST_MSP;
                    MemData   = DAT_RES;
                    MSPWrite  = 1'b1;
                end
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
        // Outputs are forced quiet for the whole reset cycle, before the state register catches up.
        if (Reset) begin
            MSPWrite  = 1'b0;
            MSPPop    = 1'b0;
            RSPWrite  = 1'b0;
            RSPPop    = 1'b0;
            PCWrite   = 1'b0;
            PCSource  = 1'b0;
            PCAdd     = 1'b0;
            ValAWrite = 1'b0;
            ValBWrite = 1'b0;
            IRWrite   = 1'b0;
            MemRead1  = 1'b0;
            MemRead2  = 1'b0;
            MemWrite1 = 1'b0;
            MemWrite2 = 1'b0;
            MemDst1   = '0;
            MemDst2   = '0;
            MemData   = '0;
            Halted    = 1'b0;
            Illegal   = 1'b0;
            State     = S_INIT;
        end
    end

endmodule

// File: tb/tb_stage5_control_fsm.sv
// Directed bench for stage5_control_fsm: per-cycle expected control vectors go through a scoreboard queue.
// Define STAGE5_CTRL_STEP_EN for both files to exercise the Step-gated FETCH.
module tb_stage5_control_fsm;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Step;
    logic [3:0] Opcode;
    logic       MSPWrite, MSPPop, RSPWrite, RSPPop;
    logic       PCWrite, PCSource, PCAdd;
    logic       ValAWrite, ValBWrite, IRWrite;
    logic       MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic [1:0] MemDst1, MemDst2;
    logic [2:0] MemData;
    logic [3:0] State;
    logic       Halted, Illegal;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [26:0] sb_q[$];
    logic [26:0] obs;

    always #5 CLK = ~CLK;

    stage5_control_fsm #(.INIT_CYCLES(5), .CNT_W(3)) dut (
        .CLK(CLK), .Reset(Reset),
`ifdef STAGE5_CTRL_STEP_EN
        .Step(Step),
`endif
        .Opcode(Opcode),
        .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
        .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
        .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
        .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .State(State), .Halted(Halted), .Illegal(Illegal)
    );

    assign obs = {MSPWrite, MSPPop, RSPWrite, RSPPop, PCWrite, PCSource, PCAdd,
                  ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
                  MemDst1, MemDst2, MemData, State, Halted, Illegal};

    localparam logic [26:0] B_MSPW = 27'd1 << 26;
    localparam logic [26:0] B_MSPP = 27'd1 << 25;
    localparam logic [26:0] B_RSPW = 27'd1 << 24;
    localparam logic [26:0] B_RSPP = 27'd1 << 23;
    localparam logic [26:0] B_PCW  = 27'd1 << 22;
    localparam logic [26:0] B_PCS  = 27'd1 << 21;
    localparam logic [26:0] B_PCA  = 27'd1 << 20;
    localparam logic [26:0] B_VAW  = 27'd1 << 19;
    localparam logic [26:0] B_VBW  = 27'd1 << 18;
    localparam logic [26:0] B_IRW  = 27'd1 << 17;
    localparam logic [26:0] B_MR1  = 27'd1 << 16;
    localparam logic [26:0] B_MW1  = 27'd1 << 14;
    localparam logic [26:0] B_MW2  = 27'd1 << 13;
    localparam logic [26:0] B_HLT  = 27'd1 << 1;
    localparam logic [26:0] B_ILL  = 27'd1;

    function automatic logic [26:0] d1(input logic [1:0] v); return 27'(v) << 11; endfunction
    function automatic logic [26:0] d2(input logic [1:0] v); return 27'(v) << 9;  endfunction
    function automatic logic [26:0] md(input logic [2:0] v); return 27'(v) << 6;  endfunction
    function automatic logic [26:0] st(input logic [3:0] v); return 27'(v) << 2;  endfunction

    // Called at posedge+1 with inputs already driven; compares, then advances one cycle.
    task automatic chk(input logic [26:0] exp, input string tag);
        logic [26:0] e;
        sb_q.push_back(exp);
        #1;
        e = sb_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input string tag);
`ifdef STAGE5_CTRL_STEP_EN
        Step = 1'b0;
        chk(st(4'h1), "fetch_wait0");
        chk(st(4'h1), "fetch_wait1");
        Step = 1'b1;
        chk(st(4'h1), "fetch_step");
        Step = 1'b0;
`endif
        chk(B_PCW | B_PCA | B_MR1 | B_IRW | d1(2'b00) | st(4'h1), tag);
    endtask

    initial begin
        Reset  = 1'b1;
        Step   = 1'b0;
        Opcode = 4'h0;
        @(posedge CLK);
        #1;
        chk('0, "reset0");
        chk('0, "reset1");
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) chk(st(4'h0), "init");
        fetch("fetch_first");

        // ALU, with IROut scrambled after DECODE to confirm the opcode latch.
        Opcode = 4'h2;
        chk(st(4'h2), "alu_decode");
        Opcode = 4'h5;
        chk(B_MR1 | d1(2'b01) | B_VAW | B_MSPW | B_MSPP | st(4'h3), "alu_ex1");
        Opcode = 4'hF;
        chk(B_MR1 | d1(2'b01) | B_VBW | B_MSPW | B_MSPP | st(4'h4), "alu_ex2");
        chk(B_MW1 | d1(2'b01) | md(3'b100) | B_MSPW | st(4'h5), "alu_ex3");
        fetch("fetch_after_alu");

        Opcode = 4'h0;
        chk(st(4'h2), "pushi_decode");
        chk(B_MW1 | d1(2'b01) | md(3'b010) | B_MSPW | st(4'h3), "pushi_ex1");
        fetch("fetch_after_pushi");

        Opcode = 4'h1;
        chk(st(4'h2), "pop_decode");
        chk(B_MSPW | B_MSPP | st(4'h3), "pop_ex1");
        fetch("fetch_after_pop");

        Opcode = 4'h3;
        chk(st(4'h2), "jump_decode");
        chk(B_PCW | st(4'h3), "jump_ex1");
        fetch("fetch_after_jump");

        Opcode = 4'h4;
        chk(st(4'h2), "call_decode");
        Opcode = 4'h9;
        chk(B_MW2 | d2(2'b10) | md(3'b101) | B_RSPW | st(4'h3), "call_ex1");
        chk(B_PCW | st(4'h4), "call_ex2");
        fetch("fetch_after_call");

        Opcode = 4'h5;
        chk(st(4'h2), "ret_decode");
        chk(B_MR1 | d1(2'b10) | B_VAW | B_RSPW | B_RSPP | st(4'h3), "ret_ex1");
        chk(B_PCW | B_PCS | st(4'h4), "ret_ex2");
        fetch("fetch_after_ret");

        Opcode = 4'h9;
        chk(st(4'h2) | B_ILL, "illegal_decode");
        fetch("fetch_after_illegal");

        // Reset in the middle of an ALU instruction.
        Opcode = 4'h2;
        chk(st(4'h2), "alu2_decode");
        chk(B_MR1 | d1(2'b01) | B_VAW | B_MSPW | B_MSPP | st(4'h3), "alu2_ex1");
        Reset = 1'b1;
        chk('0, "reset_in_ex2");
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) chk(st(4'h0), "init_after_abort");
        fetch("fetch_after_abort");

        Opcode = 4'hF;
        chk(st(4'h2), "halt_decode");
        Opcode = 4'h0;
        for (int i = 0; i < 20; i++) chk(st(4'hF) | B_HLT, "halted");
        Reset = 1'b1;
        chk('0, "reset_from_halt");
        Reset = 1'b0;
        chk(st(4'h0), "init_after_halt");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
